// File: rtl/vend_pkg.sv
// vend_pkg -- shared definitions for vending-machine display blocks.
//   state_t           : display FSM states (lamp test, blink, steady show, off)
//   CODE_MAX_W        : widest product code the onehot helper accepts
//   onehot_from_code  : product code -> one-hot lamp mask (code 0 -> no lamp)
package vend_pkg;

  typedef enum logic [1:0] {
    ST_LAMP  = 2'd0,
    ST_BLINK = 2'd1,
    ST_SHOW  = 2'd2,
    ST_OFF   = 2'd3
  } state_t;

  localparam int CODE_MAX_W = 5;

  // Bit (code-1) set for product code `code`; code 0 means "nothing selected".
  function automatic logic [31:0] onehot_from_code(input logic [CODE_MAX_W-1:0] code);
    logic [31:0] mask;
    mask = '0;
    if (code != '0) mask[code - 1'b1] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- per-product sale counter that sticks at its maximum value.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : add one sale this cycle
//   count : current sale count (registered)
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/purchase_led_ctrl.sv
// purchase_led_ctrl -- shows the most recent purchase on a row of product LEDs.
// After reset all LEDs are lit (lamp test). A purchase blinks that product's
// LED for BLINK_REPS on/off pairs of BLINK_HALF cycles each, then leaves it lit.
// clear blanks the display. One saturating sale counter per product type.
// Ports:
//   clk         : clock
//   rst         : synchronous active-high reset
//   bought_type : product code sampled every cycle, nonzero = one purchase
//   clear       : blank the display (a simultaneous purchase takes priority)
//   sel         : product code whose sale count appears on count
//   led         : registered LED row, led[i-1] belongs to product i
//   busy        : registered, high while blinking
//   count       : combinational sale count of product sel (0 for sel 0)
module purchase_led_ctrl
  import vend_pkg::*;
#(
  parameter int TYPE_W     = 2,
  parameter int BLINK_HALF = 4,
  parameter int BLINK_REPS = 3,
  parameter int CNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [TYPE_W-1:0]            bought_type,
  input  logic                         clear,
  input  logic [TYPE_W-1:0]            sel,
  output logic [(1 << TYPE_W) - 2:0]   led,
  output logic                         busy,
  output logic [CNT_W-1:0]             count
);

  localparam int NT        = (1 << TYPE_W) - 1;
  localparam int BLINK_LEN = 2 * BLINK_HALF * BLINK_REPS;
  localparam int BCNT_W    = $clog2(BLINK_LEN + 1);
  localparam int HCNT_W    = $clog2(BLINK_HALF + 1);

  state_t            state;
  logic [TYPE_W-1:0] cur_type;
  logic [BCNT_W-1:0] bcnt;   // cycles spent in BLINK since entry
  logic [HCNT_W-1:0] hcnt;   // cycles spent in the current half-period
  logic              phase;  // 1 = LED on

  logic [31:0]   new_full, cur_full;
  logic [NT-1:0] new_mask, cur_mask;
  logic          last_blink, half_end, phase_nxt;

  assign new_full = onehot_from_code(CODE_MAX_W'(bought_type));
  assign cur_full = onehot_from_code(CODE_MAX_W'(cur_type));
  assign new_mask = new_full[NT-1:0];
  assign cur_mask = cur_full[NT-1:0];

  assign last_blink = (bcnt == BCNT_W'(BLINK_LEN - 1));
  assign half_end   = (hcnt == HCNT_W'(BLINK_HALF - 1));
  assign phase_nxt  = half_end ? ~phase : phase;

  // Display FSM: purchase beats clear, and both beat whatever state we are in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_LAMP;
      led      <= '1;
      busy     <= 1'b0;
      cur_type <= '0;
      bcnt     <= '0;
      hcnt     <= '0;
      phase    <= 1'b1;
    end else if (bought_type != '0) begin
      // The LED for the new type shows on this very edge, phase "on".
      state    <= ST_BLINK;
      cur_type <= bought_type;
      bcnt     <= '0;
      hcnt     <= '0;
      phase    <= 1'b1;
      led      <= new_mask;
      busy     <= 1'b1;
    end else if (clear) begin
      state <= ST_OFF;
      led   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_BLINK: begin
          if (last_blink) begin
            state <= ST_SHOW;
            led   <= cur_mask;
            busy  <= 1'b0;
          end else begin
            bcnt  <= bcnt + 1'b1;
            hcnt  <= half_end ? '0 : hcnt + 1'b1;
            phase <= phase_nxt;
            led   <= phase_nxt ? cur_mask : '0;
          end
        end
        default: begin
          // LAMP, SHOW and OFF hold their LED pattern until the next event.
        end
      endcase
    end
  end

  // Entry 0 stands in for "no purchase" so sel indexes the array directly.
  logic [CNT_W-1:0] cnts [1 << TYPE_W];
  assign cnts[0] = '0;

  for (genvar i = 1; i <= NT; i++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (bought_type == TYPE_W'(i)),
      .count (cnts[i])
    );
  end

  assign count = cnts[sel];

endmodule

// File: tb/tb_purchase_led_ctrl.sv
// tb_purchase_led_ctrl -- self-checking bench for purchase_led_ctrl at default
// parameters. A behavioural model tracks mode, cycles since the last purchase
// and per-type sale totals; expected LEDs are derived from those by arithmetic.
module tb_purchase_led_ctrl;

  localparam int H     = 4;
  localparam int R     = 3;
  localparam int TOTAL = 2 * H * R;
  localparam int CMAX  = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] bought_type = '0;
  logic       clear = 1'b0;
  logic [1:0] sel = '0;
  logic [2:0] led;
  logic       busy;
  logic [7:0] count;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 = lamp, 1 = blink, 2 = show, 3 = off
  int m_mode = 0;
  int m_type = 0;
  int m_k    = 0;
  int m_cnt [4] = '{0, 0, 0, 0};

  purchase_led_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bought_type (bought_type),
    .clear       (clear),
    .sel         (sel),
    .led         (led),
    .busy        (busy),
    .count       (count)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_led();
    logic [2:0] lamp;
    lamp = (m_type == 0) ? 3'b000 : 3'(1 << (m_type - 1));
    case (m_mode)
      0:       return 3'b111;
      1:       return (((m_k / H) % 2) == 0) ? lamp : 3'b000;
      2:       return lamp;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic exp_busy();
    return (m_mode == 1);
  endfunction

  task automatic model_update(input int bt, input bit clr, input bit r);
    if (r) begin
      m_mode = 0; m_type = 0; m_k = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else if (bt != 0) begin
      m_mode = 1; m_type = bt; m_k = 0;
      if (m_cnt[bt] < CMAX) m_cnt[bt]++;
    end else if (clr) begin
      m_mode = 3;
    end else if (m_mode == 1) begin
      if (m_k == TOTAL - 1) m_mode = 2;
      else m_k++;
    end
  endtask

  // Apply inputs for one edge, advance the model, settle past the edge.
  task automatic step(input int bt, input bit clr, input bit r);
    bought_type = 2'(bt);
    clear       = clr;
    rst         = r;
    @(posedge clk);
    model_update(bt, clr, r);
    #2;
  endtask

  task automatic test_reset();
    step(0, 0, 1);
    step(0, 0, 1);
    checks++;
    if (led !== 3'b111) begin errors++; $display("FAIL reset_led got %b want %b", led, 3'b111); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s); #1;
      checks++;
      if (count !== 8'd0) begin errors++; $display("FAIL reset_count sel=%0d got %0d want 0", s, count); end
    end
    for (int c = 0; c < 10; c++) begin
      step(0, 0, 0);
      checks++;
      if (led !== 3'b111 || busy !== 1'b0)
        begin errors++; $display("FAIL lamp_hold cyc=%0d got led=%b busy=%b want 111/0", c, led, busy); end
    end
  endtask

  task automatic test_single_purchase();
    step(2, 0, 0);
    checks++;
    if (led !== 3'b010 || busy !== 1'b1)
      begin errors++; $display("FAIL blink_entry got led=%b busy=%b want 010/1", led, busy); end
    for (int k = 1; k <= TOTAL; k++) begin
      step(0, 0, 0);
      checks++;
      if (led !== exp_led() || busy !== exp_busy())
        begin errors++; $display("FAIL blink_seq k=%0d got led=%b busy=%b want %b/%b", k, led, busy, exp_led(), exp_busy()); end
    end
    checks++;
    if (led !== 3'b010 || busy !== 1'b0)
      begin errors++; $display("FAIL show_after_blink got led=%b busy=%b want 010/0", led, busy); end
    for (int c = 0; c < 5; c++) step(0, 0, 0);
    checks++;
    if (led !== 3'b010) begin errors++; $display("FAIL show_hold got %b want 010", led); end
    sel = 2'd2; #1;
    checks++;
    if (count !== 8'd1) begin errors++; $display("FAIL count_type2 got %0d want 1", count); end
  endtask

  task automatic test_restart();
    step(1, 0, 0);
    for (int c = 0; c < 5; c++) step(0, 0, 0);
    step(3, 0, 0);
    checks++;
    if (led !== 3'b100 || busy !== 1'b1)
      begin errors++; $display("FAIL restart_entry got led=%b busy=%b want 100/1", led, busy); end
    for (int k = 1; k <= TOTAL; k++) begin
      step(0, 0, 0);
      checks++;
      if (led !== exp_led() || busy !== exp_busy())
        begin errors++; $display("FAIL restart_seq k=%0d got led=%b busy=%b want %b/%b", k, led, busy, exp_led(), exp_busy()); end
    end
    checks++;
    if (led !== 3'b100 || busy !== 1'b0)
      begin errors++; $display("FAIL restart_show got led=%b busy=%b want 100/0", led, busy); end
    for (int s = 1; s < 4; s++) begin
      sel = 2'(s); #1;
      checks++;
      if (count !== 8'd1) begin errors++; $display("FAIL restart_count sel=%0d got %0d want 1", s, count); end
    end
  endtask

  task automatic test_clear();
    step(1, 1, 0);
    checks++;
    if (led !== 3'b001 || busy !== 1'b1)
      begin errors++; $display("FAIL clear_with_buy got led=%b busy=%b want 001/1", led, busy); end
    step(0, 0, 0);
    step(0, 1, 0);
    checks++;
    if (led !== 3'b000 || busy !== 1'b0)
      begin errors++; $display("FAIL clear_alone got led=%b busy=%b want 000/0", led, busy); end
    for (int c = 0; c < 30; c++) step(0, 0, 0);
    checks++;
    if (led !== 3'b000) begin errors++; $display("FAIL clear_hold got %b want 000", led); end
    sel = 2'd1; #1;
    checks++;
    if (count !== 8'(m_cnt[1])) begin errors++; $display("FAIL clear_count got %0d want %0d", count, m_cnt[1]); end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 300; c++) begin
      step(3, 0, 0);
      checks++;
      if (led !== 3'b100 || busy !== 1'b1)
        begin errors++; $display("FAIL sat_led cyc=%0d got led=%b busy=%b want 100/1", c, led, busy); end
    end
    sel = 2'd3; #1;
    checks++;
    if (count !== 8'd255) begin errors++; $display("FAIL sat_count got %0d want 255", count); end
    step(0, 0, 0);
  endtask

  task automatic test_reset_mid_blink();
    step(2, 0, 0);
    for (int c = 0; c < 9; c++) step(0, 0, 0);
    step(2, 0, 1);
    checks++;
    if (led !== 3'b111 || busy !== 1'b0)
      begin errors++; $display("FAIL rst_mid_blink got led=%b busy=%b want 111/0", led, busy); end
    sel = 2'd2; #1;
    checks++;
    if (count !== 8'd0) begin errors++; $display("FAIL rst_mid_count got %0d want 0", count); end
    step(0, 0, 0);
    checks++;
    if (led !== 3'b111) begin errors++; $display("FAIL rst_lamp_after got %b want 111", led); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int bt;
      bit clr, r;
      bt  = ($urandom_range(0, 9) < 2) ? int'($urandom_range(1, 3)) : 0;
      clr = ($urandom_range(0, 29) == 0);
      r   = ($urandom_range(0, 199) == 0);
      step(bt, clr, r);
      checks++;
      if (led !== exp_led() || busy !== exp_busy())
        begin errors++; $display("FAIL rand_led n=%0d got led=%b busy=%b want %b/%b", n, led, busy, exp_led(), exp_busy()); end
      sel = 2'($urandom_range(0, 3)); #1;
      checks++;
      if (count !== 8'(m_cnt[sel]))
        begin errors++; $display("FAIL rand_count n=%0d sel=%0d got %0d want %0d", n, sel, count, m_cnt[sel]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_purchase();
    test_restart();
    test_clear();
    test_saturation();
    test_reset_mid_blink();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
